bus_req_arbiter: RTL and testbench
==================================

# bus_req_arbiter

Round-robin arbiter that shares one register-block bus (the `o_bus_*` / `bus_*` request/response port driven by the APB4 slave) between `NUM_REQ` requesters, e.g. the APB4 slave and a debug or secondary bus bridge. It sequences one transaction at a time: it latches the winning request, issues it while honouring the stall inputs, and waits for `bus_ready`. It returns read data and error to the winner and aborts hung accesses with a timeout error.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (≥2)
- `ADDR_WIDTH`, 3, register address width
- `DATA_WIDTH`, 32, data and bit-enable width
- `TIMEOUT_CYCLES`, 16, cycles in ISSUE+WAIT before forced error completion (≥2)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester request; held until that requester's `req_done`
- `req_is_wr`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wr_data`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_wr_biten`  in  NUM_REQ*DATA_WIDTH  packed bit enables
- `req_done`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `req_rd_data`  out  DATA_WIDTH  read data, valid while `req_done` is asserted
- `req_err`  out  1  error, valid while `req_done` is asserted
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester
- `busy`  out  1  high in ISSUE, WAIT and DONE
- `o_bus_req`, `o_bus_req_is_wr`  out  1 each  downstream request strobe and direction
- `o_bus_addr`  out  ADDR_WIDTH; `o_bus_wr_data`, `o_bus_wr_biten`  out  DATA_WIDTH
- `bus_ready`, `bus_err`  in  1; `bus_rd_data`  in  DATA_WIDTH  downstream response
- `bus_req_stall_wr`, `bus_req_stall_rd`  in  1  downstream stall per direction

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE.** If any `req_valid` is set, select the winner round-robin. The search starts at `last+1` mod `NUM_REQ`. On the transition to ISSUE:
  - latch the winner's `is_wr`, `addr`, `wr_data` and `biten`;
  - set `last = grant_id = winner`;
  - clear the timeout counter.
- **ISSUE.**
  - `stall` = `bus_req_stall_wr` if the latched op is a write, else `bus_req_stall_rd`.
  - If `stall` is set: `o_bus_req=0`, stay in ISSUE, ignore `bus_ready`.
  - Otherwise: `o_bus_req=1` and drive the latched fields for this one cycle. If `bus_ready` is set in the same cycle, go to DONE; else go to WAIT.
- **WAIT.** `o_bus_req=0`. On `bus_ready`, capture `bus_rd_data` and `bus_err` and go to DONE.
- **Timeout.** The counter increments every cycle in ISSUE or WAIT. If the counter equals `TIMEOUT_CYCLES-1` and no completion occurs in that cycle, go to DONE with `req_err=1` and `req_rd_data=0`. A `bus_ready` in the same cycle as the timeout wins and completes normally.
- **DONE.** Drive `req_done[grant_id]=1` with the registered `req_rd_data`/`req_err`. No arbitration in this cycle, so the still-high `req_valid` is not re-granted. Next state is IDLE.
- Once latched, a request completes even if its `req_valid` drops. A requester that drops `req_valid` before it is granted is simply not selected.
- `o_bus_addr`, `o_bus_wr_data`, `o_bus_wr_biten` and `o_bus_req_is_wr` are 0 whenever `o_bus_req=0`.
- `req_rd_data` is 0 on writes and is 0 outside DONE.

## Timing
- Reset values:
  - state IDLE;
  - all `o_bus_*`, `req_done`, `req_rd_data`, `req_err`, `busy` = 0;
  - `grant_id` = 0;
  - `last` = `NUM_REQ-1`, so requester 0 wins first.
- `rst` in any state returns to IDLE on the next edge. An in-flight transaction is dropped with no `req_done` pulse.
- Minimum latency:
  - `req_valid` seen in IDLE at cycle 0;
  - `o_bus_req` in cycle 1;
  - `bus_ready` in cycle 1 gives `req_done` in cycle 2;
  - next grant decided in cycle 3.
- Maximum throughput: one transaction per 3 cycles.
- `o_bus_req` is asserted for exactly one cycle per transaction and is never re-issued.
- Outputs are decoded from registered state and latched fields only. There is no combinational path from `req_*` to `o_bus_*`.

## Test plan
- Single read, requester 0:
  - stimulus: `addr=3`, `bus_ready=1` in the `o_bus_req` cycle, `bus_rd_data=0xDEADBEEF`;
  - response: `o_bus_req` in cycle 1 with `o_bus_addr=3`, then `req_done=2'b01`, `req_rd_data=0xDEADBEEF`, `req_err=0` in cycle 2.
- Contention:
  - stimulus: requesters 0 and 1 both hold `req_valid` continuously, re-asserting after each done;
  - response: grant order 0, 1, 0, 1; `req_done` pulses 3 cycles apart.
- Stall:
  - stimulus: write from requester 1 with `bus_req_stall_wr=1` for 4 cycles, then `bus_ready` 2 cycles after issue;
  - response: `o_bus_req` rises only after the stall clears, with `o_bus_wr_data`/`biten` equal to the latched values; `req_done=2'b10`.
- Timeout:
  - stimulus: read with `bus_ready` never asserted, `TIMEOUT_CYCLES=16`;
  - response: `req_done` 17 cycles after grant, with `req_err=1` and `req_rd_data=0`.
- Error pass-through:
  - stimulus: `bus_ready` and `bus_err` both 1 in WAIT;
  - response: `req_err=1` in DONE.
- Reset in WAIT:
  - stimulus: assert `rst` during WAIT;
  - response: no `req_done`, all outputs 0, and requester 0 is granted first after reset.

Source files
------------

// File: rtl/bus_req_arbiter_if.sv
// rtl/bus_req_arbiter_if.sv - downstream register-bus request/response bundle
interface bus_req_arbiter_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                  o_bus_req;
  logic                  o_bus_req_is_wr;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_wr_data;
  logic [DATA_WIDTH-1:0] o_bus_wr_biten;
  logic                  bus_ready;
  logic                  bus_err;
  logic [DATA_WIDTH-1:0] bus_rd_data;
  logic                  bus_req_stall_wr;
  logic                  bus_req_stall_rd;

  // Arbiter side: issues requests, consumes responses and stalls
  modport master (
    output o_bus_req, o_bus_req_is_wr, o_bus_addr, o_bus_wr_data, o_bus_wr_biten,
    input  bus_ready, bus_err, bus_rd_data, bus_req_stall_wr, bus_req_stall_rd
  );

  // Register-block side: accepts requests, returns responses and stalls
  modport slave (
    input  o_bus_req, o_bus_req_is_wr, o_bus_addr, o_bus_wr_data, o_bus_wr_biten,
    output bus_ready, bus_err, bus_rd_data, bus_req_stall_wr, bus_req_stall_rd
  );
endinterface

// File: rtl/bus_req_arbiter.sv
// rtl/bus_req_arbiter.sv - round-robin arbiter sharing one register bus between requesters
module bus_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_is_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wr_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wr_biten,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [DATA_WIDTH-1:0]          req_rd_data,
  output logic                           req_err,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  bus_req_arbiter_if.master              bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_q;
  logic [ID_W-1:0]       winner;
  logic                  is_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] biten_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  err_q;
  logic                  grant;
  logic                  capture;
  logic                  to_err;
  logic                  cnt_en;
  logic                  stall;
  logic                  tmo;

  assign stall = is_wr_q ? bus.bus_req_stall_wr : bus.bus_req_stall_rd;
  assign tmo   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: scanning from the farthest candidate down, the nearest one after last wins
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[ID_W'((int'(last_q) + k) % NUM_REQ)]) begin
        winner = ID_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // Next-state and output decode; bus fields are only driven in the single issue cycle
  always_comb begin
    state_d             = state_q;
    grant               = 1'b0;
    capture             = 1'b0;
    to_err              = 1'b0;
    cnt_en              = 1'b0;
    bus.o_bus_req       = 1'b0;
    bus.o_bus_req_is_wr = 1'b0;
    bus.o_bus_addr      = '0;
    bus.o_bus_wr_data   = '0;
    bus.o_bus_wr_biten  = '0;
    req_done            = '0;
    req_rd_data         = '0;
    req_err             = 1'b0;
    busy                = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_en = 1'b1;
        if (!stall) begin
          bus.o_bus_req       = 1'b1;
          bus.o_bus_req_is_wr = is_wr_q;
          bus.o_bus_addr      = addr_q;
          bus.o_bus_wr_data   = wr_data_q;
          bus.o_bus_wr_biten  = biten_q;
          if (bus.bus_ready) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else if (tmo) begin
            to_err  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (tmo) begin
          to_err  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_en = 1'b1;
        if (bus.bus_ready) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (tmo) begin
          to_err  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        req_done[grant_id] = 1'b1;
        req_rd_data        = rd_q;
        req_err            = err_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, grant history, latched request, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      biten_q   <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q    <= winner;
        grant_id  <= winner;
        is_wr_q   <= req_is_wr[winner];
        addr_q    <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_q <= req_wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        biten_q   <= req_wr_biten[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        cnt_q     <= '0;
      end else if (cnt_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        rd_q  <= is_wr_q ? '0 : bus.bus_rd_data;
        err_q <= bus.bus_err;
      end else if (to_err) begin
        rd_q  <= '0;
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// tb/tb_bus_req_arbiter.sv - directed self-checking bench for bus_req_arbiter
module tb_bus_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_is_wr;
  logic [5:0]  req_addr;
  logic [63:0] req_wr_data;
  logic [63:0] req_wr_biten;
  logic [1:0]  req_done;
  logic [31:0] req_rd_data;
  logic        req_err;
  logic [0:0]  grant_id;
  logic        busy;
  logic [1:0]  done_seen;

  int n_checks = 0;
  int n_errors = 0;

  bus_req_arbiter_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus_if ();

  bus_req_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_wr(req_is_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_wr_biten(req_wr_biten),
    .req_done(req_done), .req_rd_data(req_rd_data), .req_err(req_err),
    .grant_id(grant_id), .busy(busy),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_is_wr = '0; req_addr = '0;
    req_wr_data = '0; req_wr_biten = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rd_data = '0;
    bus_if.bus_req_stall_wr = 1'b0; bus_if.bus_req_stall_rd = 1'b0;
    adv(); adv();
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_bus_req", bus_if.o_bus_req, 0);
    chk("rst_bus_addr", bus_if.o_bus_addr, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rd", req_rd_data, 0);
    chk("rst_err", req_err, 0);
    rst = 1'b0;

    // Single read from requester 0
    req_valid = 2'b01; req_addr[2:0] = 3'd3;
    bus_if.bus_ready = 1'b1; bus_if.bus_rd_data = 32'hDEADBEEF; #1;
    chk("t1_c0_bus_req", bus_if.o_bus_req, 0);
    adv();
    chk("t1_c1_bus_req", bus_if.o_bus_req, 1);
    chk("t1_c1_addr", bus_if.o_bus_addr, 3);
    chk("t1_c1_is_wr", bus_if.o_bus_req_is_wr, 0);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_done", req_done, 0);
    adv();
    chk("t1_c2_done", req_done, 2'b01);
    chk("t1_c2_rd", req_rd_data, 32'hDEADBEEF);
    chk("t1_c2_err", req_err, 0);
    chk("t1_c2_bus_req", bus_if.o_bus_req, 0);
    req_valid = 2'b00;
    adv();
    chk("t1_c3_done", req_done, 0);
    chk("t1_c3_rd", req_rd_data, 0);
    chk("t1_c3_busy", busy, 0);

    // Contention from a fresh reset: 0,1,0,1 with done every 3 cycles
    rst = 1'b1; adv(); rst = 1'b0;
    req_valid = 2'b11; req_addr = {3'd5, 3'd1}; bus_if.bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_idle_done", req_done, 0);
      adv();
      bus_if.bus_rd_data = 32'h100 + k; #1;
      chk("t2_grant", grant_id, k % 2);
      chk("t2_addr", bus_if.o_bus_addr, (k % 2) ? 5 : 1);
      chk("t2_issue_done", req_done, 0);
      adv();
      chk("t2_done", req_done, (k % 2) ? 2'b10 : 2'b01);
      chk("t2_rd", req_rd_data, 32'h100 + k);
      adv();
    end
    req_valid = 2'b00; bus_if.bus_ready = 1'b0;

    // Write from requester 1 stalled for 4 cycles, ready 2 cycles after issue
    req_valid = 2'b10; req_is_wr = 2'b10; req_addr[5:3] = 3'd6;
    req_wr_data[63:32] = 32'hCAFEF00D; req_wr_biten[63:32] = 32'hFFFF0000;
    bus_if.bus_req_stall_wr = 1'b1; #1;
    adv();
    req_wr_data[63:32] = 32'h12345678; #1;
    for (int s = 0; s < 4; s++) begin
      chk("t3_stall_bus_req", bus_if.o_bus_req, 0);
      chk("t3_stall_wdata", bus_if.o_bus_wr_data, 0);
      if (s < 3) adv();
    end
    adv();
    bus_if.bus_req_stall_wr = 1'b0; #1;
    chk("t3_issue_bus_req", bus_if.o_bus_req, 1);
    chk("t3_issue_wdata", bus_if.o_bus_wr_data, 32'hCAFEF00D);
    chk("t3_issue_biten", bus_if.o_bus_wr_biten, 32'hFFFF0000);
    chk("t3_issue_addr", bus_if.o_bus_addr, 6);
    chk("t3_issue_is_wr", bus_if.o_bus_req_is_wr, 1);
    chk("t3_issue_grant", grant_id, 1);
    adv();
    chk("t3_wait_bus_req", bus_if.o_bus_req, 0);
    chk("t3_wait_wdata", bus_if.o_bus_wr_data, 0);
    adv();
    bus_if.bus_ready = 1'b1; bus_if.bus_rd_data = 32'h00000BAD;
    adv();
    chk("t3_done", req_done, 2'b10);
    chk("t3_rd_zero", req_rd_data, 0);
    chk("t3_err", req_err, 0);
    req_valid = 2'b00; req_is_wr = 2'b00; bus_if.bus_ready = 1'b0;
    adv();

    // Timeout: read that never gets bus_ready
    req_valid = 2'b01; bus_if.bus_rd_data = 32'h55; #1;
    adv();
    chk("t4_issue_bus_req", bus_if.o_bus_req, 1);
    done_seen = '0;
    for (int c = 2; c <= 16; c++) begin
      adv();
      done_seen = done_seen | req_done;
    end
    chk("t4_no_early_done", done_seen, 0);
    adv();
    chk("t4_done", req_done, 2'b01);
    chk("t4_err", req_err, 1);
    chk("t4_rd_zero", req_rd_data, 0);
    req_valid = 2'b00;
    adv();

    // Error pass-through from WAIT
    req_valid = 2'b10; #1;
    adv();
    chk("t5_grant", grant_id, 1);
    chk("t5_bus_req", bus_if.o_bus_req, 1);
    adv();
    bus_if.bus_ready = 1'b1; bus_if.bus_err = 1'b1; bus_if.bus_rd_data = 32'h77;
    adv();
    chk("t5_done", req_done, 2'b10);
    chk("t5_err", req_err, 1);
    chk("t5_rd", req_rd_data, 32'h77);
    req_valid = 2'b00; bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0;
    adv();

    // bus_ready in the timeout cycle completes normally
    req_valid = 2'b01; #1;
    adv();
    for (int i = 0; i < 15; i++) adv();
    chk("t6_c16_done", req_done, 0);
    bus_if.bus_ready = 1'b1; bus_if.bus_rd_data = 32'hA5A5A5A5;
    adv();
    chk("t6_done", req_done, 2'b01);
    chk("t6_err", req_err, 0);
    chk("t6_rd", req_rd_data, 32'hA5A5A5A5);
    req_valid = 2'b00; bus_if.bus_ready = 1'b0;
    adv();

    // Reset during WAIT drops the transaction, then requester 0 wins first
    req_valid = 2'b10; #1;
    adv();
    chk("t7_grant1", grant_id, 1);
    adv();
    rst = 1'b1; req_valid = 2'b11;
    adv();
    chk("t7_rst_done", req_done, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_bus_req", bus_if.o_bus_req, 0);
    chk("t7_rst_grant", grant_id, 0);
    chk("t7_rst_err", req_err, 0);
    chk("t7_rst_rd", req_rd_data, 0);
    rst = 1'b0; bus_if.bus_ready = 1'b1; bus_if.bus_rd_data = 32'h99;
    adv();
    chk("t7_regrant", grant_id, 0);
    chk("t7_bus_req", bus_if.o_bus_req, 1);
    adv();
    chk("t7_done", req_done, 2'b01);
    chk("t7_rd", req_rd_data, 32'h99);
    req_valid = 2'b00; bus_if.bus_ready = 1'b0;
    adv();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
